demux8_dispatch_ctrl: RTL

Sequencer for the 1-to-8 demultiplexer datapath. Accepts items on a single valid/ready input stream and holds each one in a one-entry holding register. Drives the demux select and data so that each item reaches exactly one of 8 channels, which are picked by destination address or by round-robin. Applies per-channel backpressure, drops stalled items on timeout, and counts sent and dropped items.

---
 rtl/demux8_dispatch_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/demux8_dispatch_ctrl.sv
// demux8_dispatch_ctrl
// Sequencer for a 1-to-8 demux datapath. A one-entry holding register takes
// items from a valid/ready input stream. Each item goes to exactly one channel,
// chosen either by the destination address or by a round-robin search over the
// ready channels. An item stalled for TIMEOUT cycles is dropped. Sent items are
// counted with wrap-around and dropped items with saturation.
module demux8_dispatch_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [2:0]       in_dest,
  input  logic [7:0]       ch_ready,
  output logic [7:0]       ch_valid,
  output logic [2:0]       sel,
  output logic [DW-1:0]    dout,
  output logic             busy,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [7:0]       drop_cnt
);

  // The stall counter only has to reach TIMEOUT. It saturates there, so it
  // cannot wrap when the timeout is disabled.
  localparam int            SW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] TO_VAL = SW'(TIMEOUT);
  localparam bit            TO_EN  = (TIMEOUT > 0);

  typedef enum logic {IDLE, DISPATCH} state_t;

  state_t           state_q, state_d;
  logic             rdy_q;
  logic [2:0]       sel_q;
  logic [2:0]       ptr_q;
  logic [DW-1:0]    data_q;
  logic [SW-1:0]    stall_q;
  logic [CNT_W-1:0] sent_q;
  logic [7:0]       drop_q;

  logic             sel_ready;
  logic             complete;
  logic             drop;
  logic             accept;
  logic [2:0]       rr_pick;

  // Returns the first ready channel at or after ptr, wrapping modulo 8.
  // Returns ptr itself when no channel is ready.
  function automatic logic [2:0] rr_first(input logic [2:0] ptr, input logic [7:0] rdy);
    logic [2:0] idx;
    logic       found;
    rr_first = ptr;
    found    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && rdy[idx]) begin
        rr_first = idx;
        found    = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [SW-1:0] stall_inc(input logic [SW-1:0] v);
    stall_inc = (v == {SW{1'b1}}) ? v : v + SW'(1);
  endfunction

  assign sel_ready = ch_ready[sel_q];
  assign complete  = (state_q == DISPATCH) && sel_ready;
  assign drop      = TO_EN && (state_q == DISPATCH) && !sel_ready && (stall_q == TO_VAL);
  // While an item completes, a new item can be taken in the same cycle. This
  // gives back-to-back throughput of one item per cycle.
  assign in_ready  = rdy_q && ((state_q == IDLE) || complete);
  assign accept    = in_valid && in_ready;
  assign rr_pick   = rr_first(ptr_q, ch_ready);

  assign sel       = sel_q;
  assign sent_cnt  = sent_q;
  assign drop_cnt  = drop_q;

  // Next-state and output decode. In the drop cycle the channel valid is
  // withdrawn, and drop_pulse marks that cycle.
  always_comb begin
    state_d    = state_q;
    ch_valid   = 8'h00;
    dout       = '0;
    busy       = 1'b0;
    drop_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = DISPATCH;
      end
      DISPATCH: begin
        busy       = 1'b1;
        dout       = data_q;
        drop_pulse = drop;
        if (!drop) ch_valid = 8'b1 << sel_q;
        if (complete)  state_d = accept ? DISPATCH : IDLE;
        else if (drop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  // Holding register, select, round-robin pointer and stall counter. All of
  // these are loaded on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      data_q  <= '0;
      stall_q <= '0;
    end else if (accept) begin
      data_q  <= in_data;
      stall_q <= '0;
      if (mode) begin
        sel_q <= rr_pick;
        ptr_q <= rr_pick + 3'd1;
      end else begin
        sel_q <= in_dest;
      end
    end else if ((state_q == DISPATCH) && !sel_ready) begin
      stall_q <= stall_inc(stall_q);
    end
  end

  // Sent counter wraps around. Drop counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent_q <= '0;
      drop_q <= 8'h00;
    end else begin
      if (complete) sent_q <= sent_q + CNT_W'(1);
      if (drop)     drop_q <= sat_inc8(drop_q);
    end
  end

endmodule
